// File: rtl/veri_bellek_yanitlayici_pkg.sv
// ---------------------------------------------------------------------------
// veri_bellek_yanitlayici_pkg
//   Shared constants for the data-port responder and its response FIFO.
//   ADRES_BIT / VERI_BIT   : request address and data word widths
//   VERI_BYTE              : bytes per data word
//   BYTE_OFS_BIT           : low address bits that select a byte in a word
//   HIGH / LOW             : readable single-bit constants
// ---------------------------------------------------------------------------
package veri_bellek_yanitlayici_pkg;

  localparam int ADRES_BIT    = 32;
  localparam int VERI_BIT     = 32;
  localparam int VERI_BYTE    = VERI_BIT / 8;
  localparam int BYTE_OFS_BIT = $clog2(VERI_BYTE);

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage : veri_bellek_yanitlayici_pkg

// File: rtl/veri_bellek_yanitlayici_yanit_fifo.sv
// ---------------------------------------------------------------------------
// yanit_fifo
//   Synchronous FIFO that queues read responses. Pointers wrap modulo
//   DERINLIK and carry an extra lap bit so full and empty are told apart
//   when the indices are equal. Storage is cleared on reset so the head
//   reads as zero while the FIFO is idle.
//
//   Parameters : GENISLIK (entry width), DERINLIK (entry count, >= 1)
//   Ports      : clk_i, rst_i (async, active-high)
//                push_i / veri_i   - enqueue (ignored when full)
//                pop_i             - dequeue (ignored when empty)
//                veri_o            - head entry
//                dolu_o / bos_o    - full / empty flags
// ---------------------------------------------------------------------------
module yanit_fifo
  import veri_bellek_yanitlayici_pkg::*;
#(
  parameter int GENISLIK = 32,
  parameter int DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [GENISLIK-1:0] veri_i,
  input  logic                pop_i,
  output logic [GENISLIK-1:0] veri_o,
  output logic                dolu_o,
  output logic                bos_o
);

  localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam logic [AW-1:0] SON_IDX = AW'(DERINLIK - 1);

  logic [GENISLIK-1:0] depo [DERINLIK];
  logic [AW-1:0]       yaz_idx;
  logic [AW-1:0]       oku_idx;
  logic                yaz_tur;
  logic                oku_tur;
  logic                push_ok;
  logic                pop_ok;

  // Equal indices mean empty on the same lap and full one lap apart.
  assign bos_o   = (yaz_idx == oku_idx) && (yaz_tur == oku_tur);
  assign dolu_o  = (yaz_idx == oku_idx) && (yaz_tur != oku_tur);
  assign push_ok = push_i && !dolu_o;
  assign pop_ok  = pop_i && !bos_o;
  assign veri_o  = depo[oku_idx];

  // Storage and both pointers. A pointer reaching the last slot wraps to
  // zero and flips its lap bit, which keeps non power-of-two depths exact.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DERINLIK; i++) begin
        depo[i] <= '0;
      end
      yaz_idx <= '0;
      oku_idx <= '0;
      yaz_tur <= LOW;
      oku_tur <= LOW;
    end else begin
      if (push_ok) begin
        depo[yaz_idx] <= veri_i;
        if (yaz_idx == SON_IDX) begin
          yaz_idx <= '0;
          yaz_tur <= ~yaz_tur;
        end else begin
          yaz_idx <= yaz_idx + AW'(1);
        end
      end
      if (pop_ok) begin
        if (oku_idx == SON_IDX) begin
          oku_idx <= '0;
          oku_tur <= ~oku_tur;
        end else begin
          oku_idx <= oku_idx + AW'(1);
        end
      end
    end
  end

endmodule : yanit_fifo

// File: rtl/veri_bellek_yanitlayici.sv
// ---------------------------------------------------------------------------
// veri_bellek_yanitlayici
//   Responder end of the L1 data port. Requests arrive on port_istek_*;
//   writes update an internal word array, reads sample it at the accept
//   edge, travel through a fixed-latency pipeline and queue in yanit_fifo
//   before leaving on port_veri_*. A credit counter limits reads in flight
//   plus queued to YANIT_DERINLIK, so the pipeline never stalls and only
//   port_veri_hazir_i can apply backpressure.
//
//   Parameters : BELLEK_SATIR (words, power of two), GECIKME (1..4),
//                YANIT_DERINLIK (>= 1)
//   Ports      : clk_i, rst_i (async, active-high)
//                port_istek_adres_i / _gecerli_i / _yaz_i / _veri_i  request
//                port_istek_maske_i  byte enables (only with the macro)
//                port_istek_hazir_o  request can be accepted this cycle
//                port_veri_o / port_veri_gecerli_o / port_veri_hazir_i
//                                    response handshake
//
//   Build option: define VERI_YANITLAYICI_MASKE_EN to add per-byte write
//   enables; without it every write replaces the whole word.
// ---------------------------------------------------------------------------
module veri_bellek_yanitlayici
  import veri_bellek_yanitlayici_pkg::*;
#(
  parameter int BELLEK_SATIR   = 1024,
  parameter int GECIKME        = 2,
  parameter int YANIT_DERINLIK = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] port_istek_adres_i,
  input  logic                 port_istek_gecerli_i,
  input  logic                 port_istek_yaz_i,
  input  logic [VERI_BIT-1:0]  port_istek_veri_i,
`ifdef VERI_YANITLAYICI_MASKE_EN
  input  logic [VERI_BYTE-1:0] port_istek_maske_i,
`endif
  output logic                 port_istek_hazir_o,
  output logic [VERI_BIT-1:0]  port_veri_o,
  output logic                 port_veri_gecerli_o,
  input  logic                 port_veri_hazir_i
);

  localparam int SATIR_BIT = $clog2(BELLEK_SATIR);
  localparam int KREDI_BIT = $clog2(YANIT_DERINLIK) + 1;
  localparam logic [KREDI_BIT-1:0] KREDI_SINIR = KREDI_BIT'(YANIT_DERINLIK);

  logic [VERI_BIT-1:0]  bellek [BELLEK_SATIR];
  logic [SATIR_BIT-1:0] satir;
  logic                 okuma_kabul;
  logic                 yazma_kabul;
  logic [GECIKME-1:0]   boru_gecerli;
  logic [VERI_BIT-1:0]  boru_veri [GECIKME];
  logic [KREDI_BIT-1:0] kredi;
  logic [KREDI_BIT-1:0] kredi_next;
  logic                 yanit_pop;
  logic                 fifo_bos;
  logic                 fifo_dolu_unused;
  logic                 adres_unused;

  // Byte offset and bits above the word index are dropped, so addresses
  // alias modulo the array size.
  assign satir        = port_istek_adres_i[BYTE_OFS_BIT +: SATIR_BIT];
  assign adres_unused = ^port_istek_adres_i;

  assign okuma_kabul = port_istek_gecerli_i && port_istek_hazir_o && !port_istek_yaz_i;
  assign yazma_kabul = port_istek_gecerli_i && port_istek_hazir_o &&  port_istek_yaz_i;

  assign port_veri_gecerli_o = !fifo_bos;
  assign yanit_pop           = port_veri_gecerli_o && port_veri_hazir_i;

  // Word array plus the pipeline data path. The array has no reset. A read
  // samples the array at its own accept edge, so a write accepted one edge
  // earlier is already visible and a later write cannot reach it.
  always_ff @(posedge clk_i) begin
    if (yazma_kabul) begin
`ifdef VERI_YANITLAYICI_MASKE_EN
      for (int b = 0; b < VERI_BYTE; b++) begin
        if (port_istek_maske_i[b]) begin
          bellek[satir][b*8 +: 8] <= port_istek_veri_i[b*8 +: 8];
        end
      end
`else
      bellek[satir] <= port_istek_veri_i;
`endif
    end
    if (okuma_kabul) begin
      boru_veri[0] <= bellek[satir];
    end
    for (int k = 1; k < GECIKME; k++) begin
      boru_veri[k] <= boru_veri[k-1];
    end
  end

  // Pipeline valid bits. Clearing them on reset drops every in-flight read
  // so nothing partial ever reaches the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      boru_gecerli <= '0;
    end else begin
      boru_gecerli[0] <= okuma_kabul;
      for (int k = 1; k < GECIKME; k++) begin
        boru_gecerli[k] <= boru_gecerli[k-1];
      end
    end
  end

  // Credits count reads accepted but not yet popped; an accept and a pop
  // in the same cycle cancel out.
  always_comb begin
    kredi_next = kredi;
    if (okuma_kabul && !yanit_pop) begin
      kredi_next = kredi + KREDI_BIT'(1);
    end else if (!okuma_kabul && yanit_pop) begin
      kredi_next = kredi - KREDI_BIT'(1);
    end
  end

  // hazir is registered from the next credit value, so it drops at the
  // edge where the last credit is taken and returns at the first pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kredi              <= '0;
      port_istek_hazir_o <= LOW;
    end else begin
      kredi              <= kredi_next;
      port_istek_hazir_o <= (kredi_next < KREDI_SINIR) ? HIGH : LOW;
    end
  end

  yanit_fifo #(
    .GENISLIK (VERI_BIT),
    .DERINLIK (YANIT_DERINLIK)
  ) u_yanit_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (boru_gecerli[GECIKME-1]),
    .veri_i (boru_veri[GECIKME-1]),
    .pop_i  (yanit_pop),
    .veri_o (port_veri_o),
    .dolu_o (fifo_dolu_unused),
    .bos_o  (fifo_bos)
  );

endmodule : veri_bellek_yanitlayici
